note_synth: RTL and testbench

- Downstream of the record/play datapath: consumes its 32-bit note vector and turns it into a signed 16-bit audio sample stream for the audio codec interface.
- Note vector format: bit 6*f+s means string s (0..5) at fret position f (0..4); bits 31:30 are ignored.
- Up to six voices, one per string. Each voice is a square wave with a linearly decaying amplitude. All voices are summed at a fixed sample rate.

---
 rtl/note_synth_pkg.sv | 89 ++++++++
 rtl/note_synth_voice.sv | 77 +++++++
 rtl/note_synth.sv | 121 ++++++++++++
 tb/tb_note_synth.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_synth_pkg.sv
// Shared constants, note-vector indexing and the per-string/per-fret half-period table
// for the six-voice square-wave synthesiser.
package note_synth_pkg;

   localparam int NUM_STRINGS = 6;
   localparam int NUM_FRETS   = 5;
   localparam int NUM_TONES   = NUM_STRINGS * NUM_FRETS;
   localparam int PHASE_W     = 19;
   localparam int AMP_W       = 12;
   localparam int MIX_W       = 16;

   typedef logic [PHASE_W-1:0] half_t;
   typedef logic [NUM_TONES-1:0][PHASE_W-1:0] tone_table_t;

   function automatic int note_bit(input int s, input int f);
      return NUM_STRINGS * f + s;
   endfunction

   // Open-string MIDI numbers for standard tuning E2 A2 D3 G3 B3 E4.
   function automatic int open_midi(input int s);
      int m;
      case (s)
         0:       m = 40;
         1:       m = 45;
         2:       m = 50;
         3:       m = 55;
         4:       m = 59;
         default: m = 64;
      endcase
      return m;
   endfunction

   // Equal-tempered pitch in micro-hertz, A4 = 440 Hz.
   function automatic longint unsigned note_freq_uhz(input logic [6:0] midi);
      longint unsigned fu;
      case (midi)
         7'd40:   fu = 64'd82406889;
         7'd41:   fu = 64'd87307058;
         7'd42:   fu = 64'd92498606;
         7'd43:   fu = 64'd97998859;
         7'd44:   fu = 64'd103826174;
         7'd45:   fu = 64'd110000000;
         7'd46:   fu = 64'd116540940;
         7'd47:   fu = 64'd123470825;
         7'd48:   fu = 64'd130812783;
         7'd49:   fu = 64'd138591315;
         7'd50:   fu = 64'd146832384;
         7'd51:   fu = 64'd155563492;
         7'd52:   fu = 64'd164813778;
         7'd53:   fu = 64'd174614116;
         7'd54:   fu = 64'd184997211;
         7'd55:   fu = 64'd195997718;
         7'd56:   fu = 64'd207652349;
         7'd57:   fu = 64'd220000000;
         7'd58:   fu = 64'd233081881;
         7'd59:   fu = 64'd246941651;
         7'd60:   fu = 64'd261625565;
         7'd61:   fu = 64'd277182631;
         7'd62:   fu = 64'd293664768;
         7'd63:   fu = 64'd311126984;
         7'd64:   fu = 64'd329627557;
         7'd65:   fu = 64'd349228231;
         7'd66:   fu = 64'd369994423;
         7'd67:   fu = 64'd391995436;
         7'd68:   fu = 64'd415304698;
         default: fu = 64'd440000000;
      endcase
      return fu;
   endfunction

   // Elaboration-time table: round(clk_hz / (2 * freq)), indexed s*NUM_FRETS+f.
   function automatic tone_table_t build_tone_table(input longint unsigned clk_hz);
      tone_table_t     t;
      longint unsigned fu;
      t = '0;
      for (int s = 0; s < NUM_STRINGS; s++) begin
         for (int f = 0; f < NUM_FRETS; f++) begin
            fu = note_freq_uhz(7'(open_midi(s) + f));
            t[s*NUM_FRETS+f] = PHASE_W'((clk_hz * 64'd1000000 + fu) / (64'd2 * fu));
         end
      end
      return t;
   endfunction

   function automatic half_t tone_rom(input tone_table_t t, input int s, input int f);
      return t[s*NUM_FRETS+f];
   endfunction

endpackage

// File: rtl/note_synth_voice.sv
// One synth voice: square-wave oscillator with a linearly decaying amplitude,
// presented to the mixer as a signed level.
module note_synth_voice
   import note_synth_pkg::*;
#(
   parameter int unsigned AMP        = 2047,
   parameter int unsigned DECAY_STEP = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    strike,
   input  logic [PHASE_W-1:0]      strike_half,
   input  logic                    kill,
   input  logic                    decay,
   output logic [AMP_W-1:0]        amp,
   output logic signed [MIX_W-1:0] level
);

   localparam logic [AMP_W-1:0] AMP_V  = AMP_W'(AMP);
   localparam logic [AMP_W-1:0] STEP_V = AMP_W'(DECAY_STEP);

   logic [AMP_W-1:0]        amp_r, amp_nx_s;
   logic [PHASE_W-1:0]      phase_r, phase_nx_s;
   logic [PHASE_W-1:0]      half_r, half_nx_s;
   logic                    neg_r, neg_nx_s;
   logic signed [MIX_W-1:0] mag_s;

   // Next-state: oscillator runs while audible; kill beats strike beats decay.
   always_comb begin
      phase_nx_s = phase_r;
      neg_nx_s   = neg_r;
      half_nx_s  = half_r;
      amp_nx_s   = amp_r;
      if (amp_r != '0) begin
         if (phase_r == half_r - 19'd1) begin
            phase_nx_s = '0;
            neg_nx_s   = ~neg_r;
         end else begin
            phase_nx_s = phase_r + 19'd1;
         end
      end else begin
         phase_nx_s = phase_r;
      end
      if (kill) begin
         amp_nx_s = '0;
      end else if (strike) begin
         half_nx_s  = strike_half;
         phase_nx_s = '0;
         neg_nx_s   = 1'b0;
         amp_nx_s   = AMP_V;
      end else if (decay) begin
         amp_nx_s = (amp_r > STEP_V) ? (amp_r - STEP_V) : '0;
      end else begin
         amp_nx_s = amp_r;
      end
   end

   // Voice state registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         amp_r   <= '0;
         phase_r <= '0;
         half_r  <= '0;
         neg_r   <= 1'b0;
      end else begin
         amp_r   <= amp_nx_s;
         phase_r <= phase_nx_s;
         half_r  <= half_nx_s;
         neg_r   <= neg_nx_s;
      end
   end

   assign mag_s = {{(MIX_W-AMP_W){1'b0}}, amp_r};
   assign level = neg_r ? -mag_s : mag_s;
   assign amp   = amp_r;

endmodule

// File: rtl/note_synth.sv
// Six-voice note synthesiser: decodes struck strings from the note vector, mixes the
// voices at the sample rate and hands samples to the codec with a valid/ready register.
module note_synth
   import note_synth_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 50000000,
   parameter int unsigned SAMPLE_DIV    = 1042,
   parameter int unsigned AMP           = 2047,
   parameter int unsigned DECAY_SAMPLES = 24,
   parameter int unsigned DECAY_STEP    = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [31:0]             note_in,
   input  logic                    note_strobe,
   input  logic                    mute,
   input  logic                    sample_ready,
   output logic                    sample_valid,
   output logic signed [MIX_W-1:0] sample_out,
   output logic [NUM_STRINGS-1:0]  active,
   output logic                    overrun
);

   localparam tone_table_t TONES = build_tone_table(64'(CLK_HZ));
   localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam int DEC_W = (DECAY_SAMPLES > 2) ? $clog2(DECAY_SAMPLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_SAMPLES - 1);

   logic [DIV_W-1:0]        div_r;
   logic [DEC_W-1:0]        dcnt_r;
   logic                    tick_s, decay_s;
   logic [NUM_STRINGS-1:0]  hit_s, strike_s;
   half_t                   half_sel_s [NUM_STRINGS];
   logic [AMP_W-1:0]        amp_s      [NUM_STRINGS];
   logic signed [MIX_W-1:0] level_s    [NUM_STRINGS];
   logic signed [MIX_W-1:0] mix_s;
   logic                    unused_s;

   assign unused_s = ^note_in[31:30];
   assign tick_s   = (div_r == '0);
   assign decay_s  = tick_s && (dcnt_r == DEC_LAST);
   assign strike_s = hit_s & {NUM_STRINGS{note_strobe & ~mute}};

   // Sample-rate divider: tick in the cycle the count reaches zero.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_r <= '0;
      end else if (tick_s) begin
         div_r <= DIV_LAST;
      end else begin
         div_r <= div_r - 1'b1;
      end
   end

   // Decay pacing: count ticks, fire on every DECAY_SAMPLES-th one.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dcnt_r <= '0;
      end else if (tick_s) begin
         dcnt_r <= decay_s ? '0 : (dcnt_r + 1'b1);
      end else begin
         dcnt_r <= dcnt_r;
      end
   end

   // Strike decode: the highest set fret of each string selects its tone.
   always_comb begin
      for (int s = 0; s < NUM_STRINGS; s++) begin
         hit_s[s]      = 1'b0;
         half_sel_s[s] = '0;
         for (int f = 0; f < NUM_FRETS; f++) begin
            hit_s[s]      = hit_s[s] | note_in[note_bit(s, f)];
            half_sel_s[s] = note_in[note_bit(s, f)] ? tone_rom(TONES, s, f) : half_sel_s[s];
         end
      end
   end

   for (genvar g = 0; g < NUM_STRINGS; g++) begin : g_voice
      note_synth_voice #(
         .AMP        (AMP),
         .DECAY_STEP (DECAY_STEP)
      ) u_voice (
         .clk         (clk),
         .resetn      (resetn),
         .strike      (strike_s[g]),
         .strike_half (half_sel_s[g]),
         .kill        (mute),
         .decay       (decay_s),
         .amp         (amp_s[g]),
         .level       (level_s[g])
      );
      assign active[g] = (amp_s[g] != '0);
   end

   // Mixer: plain sum, six full-scale voices still fit in 16 bits signed.
   always_comb begin
      mix_s = '0;
      for (int s = 0; s < NUM_STRINGS; s++) begin
         mix_s = mix_s + level_s[s];
      end
   end

   // Output register and codec handshake; an unconsumed sample may be overwritten.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sample_valid <= 1'b0;
         sample_out   <= '0;
         overrun      <= 1'b0;
      end else if (tick_s) begin
         sample_out   <= mix_s;
         sample_valid <= 1'b1;
         overrun      <= overrun | (sample_valid & ~sample_ready);
      end else if (sample_valid && sample_ready) begin
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= sample_valid;
      end
   end

endmodule

// File: tb/tb_note_synth.sv
// Self-checking bench for note_synth: directed scenarios plus random traffic, every
// cycle compared against a time-based behavioural model of the synthesiser.
module tb_note_synth;

   localparam int CLK_HZ        = 200000;
   localparam int SAMPLE_DIV    = 8;
   localparam int AMP           = 2047;
   localparam int DECAY_SAMPLES = 4;
   localparam int DECAY_STEP    = 3;

   logic               clk = 1'b0;
   logic               resetn;
   logic [31:0]        note_in;
   logic               note_strobe;
   logic               mute;
   logic               sample_ready;
   logic               sample_valid;
   logic signed [15:0] sample_out;
   logic [5:0]         active;
   logic               overrun;

   always #5 clk = ~clk;

   note_synth #(
      .CLK_HZ        (CLK_HZ),
      .SAMPLE_DIV    (SAMPLE_DIV),
      .AMP           (AMP),
      .DECAY_SAMPLES (DECAY_SAMPLES),
      .DECAY_STEP    (DECAY_STEP)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .note_in      (note_in),
      .note_strobe  (note_strobe),
      .mute         (mute),
      .sample_ready (sample_ready),
      .sample_valid (sample_valid),
      .sample_out   (sample_out),
      .active       (active),
      .overrun      (overrun)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: clocks since reset, ticks seen, and per voice its amplitude, half period
   // and the number of audible clocks since it was struck.
   int m_cyc, m_ticks, m_data;
   int m_amp  [6];
   int m_half [6];
   int m_age  [6];
   int m_tone [30];
   bit m_valid, m_ovr, m_loaded;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   function automatic int exp_half(input int s, input int f);
      int  semis;
      real freq;
      case (s)
         0:       semis = -29;
         1:       semis = -24;
         2:       semis = -19;
         3:       semis = -14;
         4:       semis = -10;
         default: semis = -5;
      endcase
      freq = 440.0 * $pow(2.0, real'(semis + f) / 12.0);
      return $rtoi(real'(CLK_HZ) / (2.0 * freq) + 0.5);
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_ticks = 0; m_data = 0;
      m_valid = 1'b0; m_ovr = 1'b0; m_loaded = 1'b0;
      for (int s = 0; s < 6; s++) begin
         m_amp[s] = 0; m_half[s] = 0; m_age[s] = 0;
      end
   endtask

   task automatic model_step(input bit stb, input logic [31:0] note, input bit mt, input bit rdy);
      bit tick, dec;
      int mix, fret;
      tick = ((m_cyc % SAMPLE_DIV) == 0);
      mix  = 0;
      for (int s = 0; s < 6; s++) begin
         if (m_amp[s] != 0)
            mix += (((m_age[s] / m_half[s]) % 2) == 1) ? -m_amp[s] : m_amp[s];
      end
      m_loaded = tick;
      if (tick) begin
         if (m_valid && !rdy) m_ovr = 1'b1;
         m_valid = 1'b1;
         m_data  = mix;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      dec = 1'b0;
      if (tick) begin
         m_ticks++;
         dec = ((m_ticks % DECAY_SAMPLES) == 0);
      end
      for (int s = 0; s < 6; s++) begin
         fret = -1;
         for (int f = 0; f < 5; f++) if (note[6*f+s]) fret = f;
         if (mt) begin
            m_amp[s] = 0;
         end else if (stb && fret >= 0) begin
            m_half[s] = m_tone[s*5+fret];
            m_age[s]  = 0;
            m_amp[s]  = AMP;
         end else begin
            if (m_amp[s] != 0) m_age[s]++;
            if (dec) m_amp[s] = (m_amp[s] > DECAY_STEP) ? m_amp[s] - DECAY_STEP : 0;
         end
      end
      m_cyc++;
   endtask

   task automatic compare_all();
      logic [5:0] act;
      for (int s = 0; s < 6; s++) act[s] = (m_amp[s] != 0);
      check_eq("sample_valid", {31'd0, sample_valid}, {31'd0, m_valid});
      check_eq("sample_out", {16'h0000, sample_out}, {16'h0000, m_data[15:0]});
      check_eq("active", {26'd0, active}, {26'd0, act});
      check_eq("overrun", {31'd0, overrun}, {31'd0, m_ovr});
   endtask

   // One clock: drive inputs after a falling edge, advance the model, check at the next.
   task automatic cycle(input bit stb, input logic [31:0] note, input bit mt, input bit rdy);
      note_strobe  = stb;
      note_in      = note;
      mute         = mt;
      sample_ready = rdy;
      model_step(stb, note, mt, rdy);
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_valid"}, {31'd0, sample_valid}, 32'd0);
      check_eq({tag, "_out"}, {16'h0000, sample_out}, 32'd0);
      check_eq({tag, "_active"}, {26'd0, active}, 32'd0);
      check_eq({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      for (int i = 0; i < 30; i++) m_tone[i] = exp_half(i / 5, i % 5);
      resetn = 1'b0; note_in = 32'd0; note_strobe = 1'b0; mute = 1'b0; sample_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      resetn = 1'b1;

      // First sample after release: zero, valid one cycle after the first tick.
      cycle(1'b0, 32'd0, 1'b0, 1'b0);
      check_eq("first_valid", {31'd0, sample_valid}, 32'd1);
      check_eq("first_sample", {16'h0000, sample_out}, 32'd0);
      repeat (10) cycle(1'b0, 32'd0, 1'b0, 1'b1);

      // Full chord: first post-strike sample is six positive full-scale voices.
      cycle(1'b1, 32'h0000_003F, 1'b0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 2*SAMPLE_DIV && !seen; i++) begin
         cycle(1'b0, 32'd0, 1'b0, 1'b1);
         if (m_loaded) begin
            seen = 1'b1;
            check_eq("chord_sample", {16'h0000, sample_out}, 32'd12282);
            check_eq("chord_active", {26'd0, active}, 32'h3F);
         end
      end
      check_eq("chord_sample_seen", {31'd0, seen}, 32'd1);

      // Mute with a simultaneous strobe: mute wins, output goes silent.
      cycle(1'b1, 32'h0000_003F, 1'b1, 1'b1);
      check_eq("mute_active", {26'd0, active}, 32'd0);
      repeat (2*SAMPLE_DIV) cycle(1'b0, 32'd0, 1'b0, 1'b1);
      check_eq("mute_sample", {16'h0000, sample_out}, 32'd0);

      // Single strike on the low E string, long enough for several polarity flips.
      cycle(1'b1, 32'h0000_0001, 1'b0, 1'b1);
      check_eq("single_active", {26'd0, active}, 32'h01);
      repeat (2600) cycle(1'b0, 32'd0, 1'b0, 1'b1);
      cycle(1'b0, 32'd0, 1'b1, 1'b1);

      // Fret priority: frets 0 and 1 on string 0 -> fret 1 tone.
      cycle(1'b1, 32'h0000_0041, 1'b0, 1'b1);
      check_eq("fret_active", {26'd0, active}, 32'h01);
      repeat (2500) cycle(1'b0, 32'd0, 1'b0, 1'b1);

      // Backpressure across two ticks, then a single-cycle accept.
      repeat (2*SAMPLE_DIV + 2) cycle(1'b0, 32'd0, 1'b0, 1'b0);
      check_eq("overrun_set", {31'd0, overrun}, 32'd1);
      check_eq("overrun_valid", {31'd0, sample_valid}, 32'd1);
      for (int i = 0; i < SAMPLE_DIV && (m_cyc % SAMPLE_DIV) == 0; i++)
         cycle(1'b0, 32'd0, 1'b0, 1'b0);
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
      check_eq("handshake_drop", {31'd0, sample_valid}, 32'd0);
      cycle(1'b0, 32'd0, 1'b0, 1'b0);

      // Random traffic with a reset asserted in the middle.
      for (int i = 0; i < 6000; i++) begin
         if (i == 3000) begin
            resetn = 1'b0;
            note_strobe = 1'b0;
            #1;
            check_all_zero("midreset");
            model_reset();
            @(negedge clk);
            @(negedge clk);
            resetn = 1'b1;
         end
         cycle(($urandom_range(0, 63) == 0), $urandom(), ($urandom_range(0, 199) == 0),
               ($urandom_range(0, 3) != 0));
      end

      // Decay of a lone voice all the way to silence.
      cycle(1'b0, 32'd0, 1'b1, 1'b1);
      cycle(1'b1, 32'h0000_0001, 1'b0, 1'b1);
      check_eq("decay_start", {26'd0, active}, 32'h01);
      repeat (22000) cycle(1'b0, 32'd0, 1'b0, 1'b1);
      check_eq("decay_active", {26'd0, active}, 32'd0);
      check_eq("decay_sample", {16'h0000, sample_out}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
